// File: rtl/perf_pkg.sv
// perf_pkg: register offsets, FSM encoding and requester ids for perf_counter_ctrl.
package perf_pkg;

  localparam logic [31:0] OFF_CYCLE   = 32'h0;
  localparam logic [31:0] OFF_INSTRET = 32'h4;
  localparam logic [31:0] OFF_CLEAR   = 32'h8;
  localparam logic [31:0] OFF_CTRL    = 32'hC;
  localparam logic [31:0] OFF_EVT0    = 32'h10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESP  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/perf_counter_ctrl_if.sv
// perf_counter_ctrl_if: one MMIO requester channel (request handshake + registered response).
interface perf_counter_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req_valid, addr, we, wdata, input req_ready, rvalid, rdata);
  modport slave  (input req_valid, addr, we, wdata, output req_ready, rvalid, rdata);
endinterface

// File: rtl/perf_counter_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; pointer moves to the loser after each grant.
module rr_arbiter2
  import perf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;

  // Grant the lone requester, or the pointed-at one on a tie.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (ptr == REQ_DBG) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer names the requester that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= REQ_CPU;
    else if (|gnt) ptr <= gnt[0] ? REQ_DBG : REQ_CPU;
  end
endmodule

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: cycle/instret/event counter bank behind a shared two-port MMIO window.
// Optional feature: define PERF_SNAPSHOT_EN for CTRL-triggered shadow snapshots (bit31 snap, bit30 select).
module perf_counter_ctrl
  import perf_pkg::*;
#(
  parameter int          NUM_EVT   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_valid,
  input  logic [NUM_EVT-1:0] evt,
  perf_counter_ctrl_if.slave cpu,
  perf_counter_ctrl_if.slave dbg,
  output logic               busy
);
  localparam int            NCNT     = NUM_EVT + 2;
  localparam int            IW       = $clog2(NCNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCNT - 1);

  state_t                state, state_nxt;
  logic [NCNT-1:0][31:0] cnt;
  logic [NCNT-1:0][31:0] cnt_rd;
  logic [NCNT-1:0]       inc;
  logic [NUM_EVT:0]      en;
  logic [IW-1:0]         clr_idx;
  logic [1:0]            gnt;
  logic                  arb_en, win, resp_id;
  logic [31:0]           a_addr, ctrl_rd, rd_data;
  logic                  a_we;
  logic [NUM_EVT:0]      a_en;
  logic                  acc, hit_ctrl, do_clear, do_ctrl, clr_last;
  logic                  cpu_rv, dbg_rv;
  logic [31:0]           cpu_rd, dbg_rd;

  // Arbitration only while idle and out of reset, so ready is low during reset.
  assign arb_en = (state == S_IDLE) & rst_n;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({dbg.req_valid, cpu.req_valid}),
    .gnt   (gnt)
  );

  assign win      = gnt[1];
  assign acc      = |gnt;
  assign a_addr   = win ? dbg.addr : cpu.addr;
  assign a_we     = win ? dbg.we   : cpu.we;
  assign a_en     = win ? dbg.wdata[NUM_EVT:0] : cpu.wdata[NUM_EVT:0];
  assign hit_ctrl = (a_addr == BASE_ADDR + OFF_CTRL);
  assign do_clear = acc & a_we & (a_addr == BASE_ADDR + OFF_CLEAR);
  assign do_ctrl  = acc & a_we & hit_ctrl;
  assign clr_last = (state == S_CLEAR) && (clr_idx == LAST_IDX);

  assign cpu.req_ready = gnt[0];
  assign dbg.req_ready = gnt[1];
  assign cpu.rvalid    = cpu_rv;
  assign cpu.rdata     = cpu_rd;
  assign dbg.rvalid    = dbg_rv;
  assign dbg.rdata     = dbg_rd;
  assign busy          = (state != S_IDLE);

  // Counter order: CYCLE, INSTRET, EVT[0..]; CYCLE and INSTRET share enable bit 0.
  assign inc = {en[NUM_EVT:1] & evt, en[0] & inst_valid, en[0]};

`ifdef PERF_SNAPSHOT_EN
  logic [NCNT-1:0][31:0] shadow;
  logic                  snap_sel;
  logic [1:0]            a_snap;

  assign a_snap  = win ? dbg.wdata[31:30] : cpu.wdata[31:30];
  assign cnt_rd  = snap_sel ? shadow : cnt;
  assign ctrl_rd = 32'(en) | {1'b0, snap_sel, 30'b0};

  // Snapshot copies pre-increment values; bit31 is a pulse, bit30 is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      snap_sel <= 1'b0;
    end else if (do_ctrl) begin
      snap_sel <= a_snap[0];
      if (a_snap[1]) shadow <= cnt;
    end
  end
`else
  assign cnt_rd  = cnt;
  assign ctrl_rd = 32'(en);
`endif

  // Read mux on the granted address; anything unmapped reads 0.
  always_comb begin
    rd_data = '0;
    if (a_addr == BASE_ADDR + OFF_CYCLE)   rd_data = cnt_rd[0];
    if (a_addr == BASE_ADDR + OFF_INSTRET) rd_data = cnt_rd[1];
    if (hit_ctrl)                          rd_data = ctrl_rd;
    for (int i = 0; i < NUM_EVT; i++)
      if (a_addr == BASE_ADDR + OFF_EVT0 + 32'(4 * i)) rd_data = cnt_rd[2 + i];
  end

  // Counters: the one under clear is zeroed, the rest keep counting (wrap naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else begin
      for (int k = 0; k < NCNT; k++) begin
        if (state == S_CLEAR && clr_idx == IW'(k)) cnt[k] <= '0;
        else if (inc[k])                           cnt[k] <= cnt[k] + 32'd1;
      end
    end
  end

  // CTRL enables come out of reset all set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       en <= '1;
    else if (do_ctrl) en <= a_en;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc) state_nxt = do_clear ? S_CLEAR : S_RESP;
      S_CLEAR: if (clr_idx == LAST_IDX) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, clear walker and the id of the port owed a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_idx <= '0;
      resp_id <= REQ_CPU;
    end else begin
      state <= state_nxt;
      if (acc) resp_id <= win;
      if (state == S_CLEAR) clr_idx <= clr_idx + IW'(1);
      else                  clr_idx <= '0;
    end
  end

  // Registered responses: one-cycle strobe to the owner, zeros elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cpu_rv, dbg_rv, cpu_rd, dbg_rd} <= '0;
    end else begin
      {cpu_rv, dbg_rv, cpu_rd, dbg_rd} <= '0;
      if (acc && !do_clear) begin
        if (win == REQ_DBG) begin
          dbg_rv <= 1'b1;
          dbg_rd <= a_we ? 32'd0 : rd_data;
        end else begin
          cpu_rv <= 1'b1;
          cpu_rd <= a_we ? 32'd0 : rd_data;
        end
      end else if (clr_last) begin
        if (resp_id == REQ_DBG) dbg_rv <= 1'b1;
        else                    cpu_rv <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// tb_perf_counter_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_perf_counter_ctrl;
  localparam int          NUM_EVT = 4;
  localparam int          NC      = NUM_EVT + 2;
  localparam logic [31:0] BASE    = 32'h8000_0010;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               inst_valid = 1'b0;
  logic [NUM_EVT-1:0] evt = '0;
  logic               busy;

  perf_counter_ctrl_if cpu ();
  perf_counter_ctrl_if dbg ();

  perf_counter_ctrl #(.NUM_EVT(NUM_EVT), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .evt        (evt),
    .cpu        (cpu),
    .dbg        (dbg),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [31:0]      m_cnt [NC];
  logic [NUM_EVT:0] m_en;
  int               m_rr;
  int               m_busy;
  bit               m_clr;
  int               m_rport;
  logic [31:0]      m_rdata;
`ifdef PERF_SNAPSHOT_EN
  logic [31:0]      m_shd [NC];
  bit               m_sel;
`endif

  // requester state (held until accepted)
  bit          rq_v  [2];
  logic [31:0] rq_a  [2];
  bit          rq_we [2];
  logic [31:0] rq_wd [2];

  logic [31:0] last_rdata;
  logic        last_rport;
  logic [NC-1:0][31:0] pre_v;
  logic [31:0] atab [11] = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 16, BASE + 20,
                             BASE + 24, BASE + 28, BASE + 32, BASE + 2, 32'h10};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ctrl();
    logic [31:0] r;
    r = 32'(m_en);
`ifdef PERF_SNAPSHOT_EN
    if (m_sel) r[30] = 1'b1;
`endif
    return r;
  endfunction

  // Register map evaluated by offset arithmetic.
  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off, r;
    logic [31:0] v [NC];
    off = a - BASE;
    v = m_cnt;
    r = '0;
`ifdef PERF_SNAPSHOT_EN
    if (m_sel) v = m_shd;
`endif
    if (off[1:0] == 2'b00) begin
      if (off < 8)                                    r = v[off[2]];
      else if (off == 32'hC)                          r = m_ctrl();
      else if (off >= 16 && (off - 16) / 4 < NUM_EVT) r = v[2 + int'((off - 16) / 4)];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_cnt[k] = '0;
    m_en = '1; m_rr = 0; m_busy = 0; m_clr = 1'b0; m_rport = 0; m_rdata = '0;
`ifdef PERF_SNAPSHOT_EN
    for (int k = 0; k < NC; k++) m_shd[k] = '0;
    m_sel = 1'b0;
`endif
  endtask

  task automatic drive();
    cpu.req_valid = rq_v[0]; cpu.addr = rq_a[0]; cpu.we = rq_we[0]; cpu.wdata = rq_wd[0];
    dbg.req_valid = rq_v[1]; dbg.addr = rq_a[1]; dbg.we = rq_we[1]; dbg.wdata = rq_wd[1];
  endtask

  // One clock: drive, check outputs against the model, advance the model across the edge.
  task automatic step();
    int gp, clr_k;
    bit ctrl_wr, on, s;
    logic [31:0] wd;
    logic [31:0] pre [NC];
    drive();
    #1;
    gp = -1;
    if (m_busy == 0) begin
      if (rq_v[0] && rq_v[1]) gp = m_rr;
      else if (rq_v[0])       gp = 0;
      else if (rq_v[1])       gp = 1;
    end
    chk("cpu_ready", 32'(cpu.req_ready), 32'(gp == 0));
    chk("dbg_ready", 32'(dbg.req_ready), 32'(gp == 1));
    chk("busy", 32'(busy), 32'(m_busy > 0));
    chk("cpu_rvalid", 32'(cpu.rvalid), 32'(m_busy == 1 && m_rport == 0));
    chk("dbg_rvalid", 32'(dbg.rvalid), 32'(m_busy == 1 && m_rport == 1));
    chk("cpu_rdata", cpu.rdata, (m_busy == 1 && m_rport == 0) ? m_rdata : 32'd0);
    chk("dbg_rdata", dbg.rdata, (m_busy == 1 && m_rport == 1) ? m_rdata : 32'd0);
    if (m_busy == 1) begin
      last_rdata = m_rport == 1 ? dbg.rdata : cpu.rdata;
      last_rport = dbg.rvalid;
    end
    pre = m_cnt;
    clr_k = -1; ctrl_wr = 1'b0; wd = '0;
    if (m_busy > 0) begin
      if (m_clr && m_busy > 1) clr_k = NC + 1 - m_busy;
      m_busy--;
      if (m_busy == 0) m_clr = 1'b0;
    end else if (gp >= 0) begin
      m_rr = (gp == 0) ? 1 : 0;
      m_rport = gp;
      if (rq_we[gp] && rq_a[gp] == BASE + 32'h8) begin
        m_busy = NC + 1; m_clr = 1'b1; m_rdata = '0;
      end else begin
        m_busy = 1;
        m_rdata = rq_we[gp] ? 32'd0 : m_read(rq_a[gp]);
        ctrl_wr = rq_we[gp] && rq_a[gp] == BASE + 32'hC;
        wd = rq_wd[gp];
      end
      rq_v[gp] = 1'b0;
    end
    for (int k = 0; k < NC; k++) begin
      on = (k < 2) ? m_en[0] : m_en[k - 1];
      s  = (k == 0) ? 1'b1 : (k == 1) ? inst_valid : evt[k - 2];
      if (k == clr_k)  m_cnt[k] = '0;
      else if (on & s) m_cnt[k] = m_cnt[k] + 32'd1;
    end
    if (ctrl_wr) begin
      m_en = wd[NUM_EVT:0];
`ifdef PERF_SNAPSHOT_EN
      if (wd[31]) m_shd = pre;
      m_sel = wd[30];
`endif
    end
    @(negedge clk);
  endtask

  task automatic xact(input int p, input logic [31:0] a, input bit we, input logic [31:0] wd);
    rq_v[p] = 1'b1; rq_a[p] = a; rq_we[p] = we; rq_wd[p] = wd;
    for (int n = 0; n < 40 && (rq_v[p] || m_busy > 0); n++) step();
  endtask

  // Entered just after a negedge; asserts reset asynchronously before the next posedge.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cpu_ready", 32'(cpu.req_ready), 0);
    chk("rst_dbg_ready", 32'(dbg.req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_rvalid", 32'(cpu.rvalid), 0);
    chk("rst_dbg_rvalid", 32'(dbg.rvalid), 0);
    chk("rst_rdata", cpu.rdata | dbg.rdata, 0);
    rq_v[0] = 1'b0; rq_v[1] = 1'b0;
    inst_valid = 1'b0; evt = '0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      rq_v[p] = 1'b0; rq_a[p] = '0; rq_we[p] = 1'b0; rq_wd[p] = '0;
    end
    rq_v[0] = 1'b1; rq_v[1] = 1'b1;   // requests held during reset must see ready=0
    drive();
    @(negedge clk);
    reset_pulse();

    // 10 idle cycles then CPU reads CYCLE
    repeat (10) step();
    xact(0, BASE, 1'b0, '0);
    chk("cycle_after_10", last_rdata, 32'd10);

    // simultaneous INSTRET reads straight out of reset
    reset_pulse();
    rq_v[0] = 1'b1; rq_a[0] = BASE + 4; rq_we[0] = 1'b0;
    rq_v[1] = 1'b1; rq_a[1] = BASE + 4; rq_we[1] = 1'b0;
    inst_valid = 1'b1;
    step(); step();
    chk("first_grant_is_cpu", 32'(last_rport), 0);
    for (int n = 0; n < 10 && (rq_v[1] || m_busy > 0); n++) step();
    chk("second_grant_is_dbg", 32'(last_rport), 1);
    inst_valid = 1'b0;

    // only CYCLE/INSTRET enabled, pulse evt[0] five times
    xact(0, BASE + 12, 1'b1, 32'h1);
    for (int n = 0; n < 5; n++) begin evt = 4'b0001; step(); evt = '0; step(); end
    xact(1, BASE + 16, 1'b0, '0);
    xact(0, BASE, 1'b0, '0);
    xact(1, BASE + 12, 1'b1, 32'h1F);

    // wrap EVT[0] from all-ones
    pre_v = {32'd7, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'd50, 32'd100};
    force dut.cnt = pre_v;
    #1 release dut.cnt;
    for (int k = 0; k < NC; k++) m_cnt[k] = pre_v[k];
    evt = 4'b0001; step(); step(); evt = '0;
    xact(0, BASE + 16, 1'b0, '0);
    chk("evt0_wrap", last_rdata, 32'h1);

    // debug-port clear, then read back every counter
    inst_valid = 1'b1; evt = 4'b1111;
    xact(1, BASE + 8, 1'b1, '0);
    inst_valid = 1'b0; evt = '0;
    for (int k = 0; k < 6; k++) xact(k % 2, (k < 2) ? BASE + 32'(4 * k) : BASE + 32'(16 + 4 * (k - 2)), 1'b0, '0);

    // reset in the middle of a clear: no ack, CTRL back to all enables
    rq_v[1] = 1'b1; rq_a[1] = BASE + 8; rq_we[1] = 1'b1; rq_wd[1] = '0;
    step(); step(); step();
    reset_pulse();
    xact(0, BASE + 12, 1'b0, '0);
    chk("ctrl_after_reset", last_rdata, 32'h1F);
    xact(1, BASE + 4, 1'b0, '0);

    // random traffic on both ports
    for (int n = 0; n < 3000; n++) begin
      inst_valid = 1'($urandom_range(0, 1));
      evt = NUM_EVT'($urandom);
      for (int p = 0; p < 2; p++) begin
        if (!rq_v[p] && $urandom_range(0, 1) == 1) begin
          int r;
          r = $urandom_range(0, 23);
          rq_v[p] = 1'b1;
          if (r == 0) begin
            rq_a[p] = BASE + 8; rq_we[p] = 1'b1; rq_wd[p] = $urandom;
          end else if (r <= 3) begin
            rq_a[p] = BASE + 12; rq_we[p] = 1'b1; rq_wd[p] = $urandom;
          end else begin
            rq_a[p] = atab[$urandom_range(0, 10)];
            rq_we[p] = ($urandom_range(0, 3) == 0);
            rq_wd[p] = $urandom;
            if (rq_we[p] && (rq_a[p] == BASE + 8 || rq_a[p] == BASE + 12)) rq_we[p] = 1'b0;
          end
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
